// File: rtl/gnss_pkg.sv
// Shared types and constants for the GNSS UART block.
package gnss_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/gnss_uart_ch.sv
// One UART channel: RX synchroniser, RX FSM, first-word-fall-through RX FIFO, TX FSM.
//   state    | meaning
//   RX_IDLE  | line high, waiting for a falling edge
//   RX_START | timing to start-bit centre, rejecting glitches
//   RX_DATA  | sampling 8 data bits LSB first
//   RX_STOP  | sampling stop bit, push or flag framing error
//   RX_BREAK | line held low after framing error, wait for high
//   TX_IDLE  | ready for a byte
//   TX_START | driving start bit
//   TX_DATA  | driving 8 data bits LSB first
//   TX_STOP  | driving stop bit
module gnss_uart_ch
    import gnss_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overflow,
    output logic                 frame_err,
    input  logic                 err_clear
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_sync_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_push, ferr_set;

    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                 fifo_empty, fifo_full, pop, push_ok;
    logic                 ovf_q, ovf_d, ferr_q, ferr_d;

    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d, tx_ready_q, tx_ready_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_cnt_q != '0) ? rx_cnt_q - CW'(1) : rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = HALF_LOAD;
            end
            RX_START: if (rx_cnt_q == '0) begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = FULL_LOAD;
                    rx_idx_d   = '0;
                end
            end
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                rx_cnt_d   = FULL_LOAD;
                rx_idx_d   = rx_idx_q + 3'd1;
                if (rx_idx_q == LAST_BIT) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == '0) begin
                if (rx_sync_q) begin
                    rx_push    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    ferr_set   = 1'b1;
                    rx_state_d = RX_BREAK;
                end
            end
            RX_BREAK: if (rx_sync_q) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && rx_ready;
        push_ok    = rx_push && (!fifo_full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        ovf_d      = (rx_push && !push_ok) ? 1'b1 : (err_clear ? 1'b0 : ovf_q);
        ferr_d     = ferr_set ? 1'b1 : (err_clear ? 1'b0 : ferr_q);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q != '0) ? tx_cnt_q - CW'(1) : tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d       = 1'b1;
                tx_ready_d = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_cnt_d   = FULL_LOAD;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            TX_START: if (tx_cnt_q == '0) begin
                tx_state_d = TX_DATA;
                tx_d       = tx_shift_q[0];
                tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                tx_cnt_d   = FULL_LOAD;
                tx_idx_d   = '0;
            end
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = FULL_LOAD;
                if (tx_idx_q == LAST_BIT) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    tx_idx_d   = tx_idx_q + 3'd1;
                end
            end
            TX_STOP: if (tx_cnt_q == '0) begin
                tx_state_d = TX_IDLE;
                tx_ready_d = 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    assign uart_tx     = tx_q;
    assign tx_ready    = tx_ready_q;
    assign rx_valid    = !fifo_empty;
    assign rx_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_overflow = ovf_q;
    assign frame_err   = ferr_q;

endmodule

// File: rtl/gnss_uart.sv
// Multi-channel GNSS UART: one independent gnss_uart_ch per channel plus the
// RTK fix-status synchroniser.
module gnss_uart
    import gnss_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   uart_rx,
    output logic [NUM_CH-1:0]   uart_tx,
    input  logic [NUM_CH*8-1:0] tx_data,
    input  logic [NUM_CH-1:0]   tx_valid,
    output logic [NUM_CH-1:0]   tx_ready,
    output logic [NUM_CH*8-1:0] rx_data,
    output logic [NUM_CH-1:0]   rx_valid,
    input  logic [NUM_CH-1:0]   rx_ready,
    output logic [NUM_CH-1:0]   rx_overflow,
    output logic [NUM_CH-1:0]   frame_err,
    input  logic                err_clear,
    input  logic                rtk_status,
    output logic                rtk_status_sync
);

    logic rtk_meta_q, rtk_sync_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        gnss_uart_ch #(
            .CLKS_PER_BIT (CLKS_PER_BIT),
            .FIFO_DEPTH   (FIFO_DEPTH)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .uart_rx     (uart_rx[n]),
            .uart_tx     (uart_tx[n]),
            .tx_data     (tx_data[8*n +: 8]),
            .tx_valid    (tx_valid[n]),
            .tx_ready    (tx_ready[n]),
            .rx_data     (rx_data[8*n +: 8]),
            .rx_valid    (rx_valid[n]),
            .rx_ready    (rx_ready[n]),
            .rx_overflow (rx_overflow[n]),
            .frame_err   (frame_err[n]),
            .err_clear   (err_clear)
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtk_meta_q <= 1'b0;
            rtk_sync_q <= 1'b0;
        end else begin
            rtk_meta_q <= rtk_status;
            rtk_sync_q <= rtk_meta_q;
        end
    end

    assign rtk_status_sync = rtk_sync_q;

endmodule

// File: tb/tb_gnss_uart.sv
// Directed bench for gnss_uart: loopback, glitch, framing, overflow, reset abort, status sync.
module tb_gnss_uart;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  uart_rx, uart_tx;
    logic [15:0] tx_data;
    logic [1:0]  tx_valid, tx_ready;
    logic [15:0] rx_data;
    logic [1:0]  rx_valid, rx_ready, rx_overflow, frame_err;
    logic        err_clear, rtk_status, rtk_status_sync;
    logic        rx0_drv, rx1_drv, loop_en;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign uart_rx = {(loop_en ? uart_tx[0] : rx1_drv), rx0_drv};

    gnss_uart #(
        .NUM_CH       (2),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rx         (uart_rx),
        .uart_tx         (uart_tx),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rx_overflow     (rx_overflow),
        .frame_err       (frame_err),
        .err_clear       (err_clear),
        .rtk_status      (rtk_status),
        .rtk_status_sync (rtk_status_sync)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one byte on ch0 TX; tx_data is scrambled while busy and must be ignored.
    task automatic tx_send(input logic [7:0] b, input string tag);
        int cyc;
        tx_data[7:0] = b;
        tx_valid[0]  = 1'b1;
        @(negedge clk);
        tx_valid[0]  = 1'b0;
        tx_data[7:0] = ~b;
        check({tag, "_start_low"}, uart_tx[0], 1'b0);
        cyc = 0;
        while (tx_ready[0] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_busy_cycles"}, cyc, 80);
    endtask

    task automatic rx_send(input int ch, input logic [7:0] b, input logic stop_bit, input bit pulse_pop);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (ch == 0) rx0_drv = frame[i];
            else         rx1_drv = frame[i];
            if (i == 9 && pulse_pop) begin
                repeat (CPB - 2) @(negedge clk);
                check("ovf2_head_before_pop", rx_data[7:0], 8'h01);
                rx_ready[0] = 1'b1;
                @(negedge clk);
                rx_ready[0] = 1'b0;
                @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
    endtask

    task automatic pop_check(input int ch, input logic [7:0] exp, input string tag);
        check({tag, "_valid"}, rx_valid[ch], 1'b1);
        check({tag, "_data"}, rx_data[8*ch +: 8], exp);
        rx_ready[ch] = 1'b1;
        @(negedge clk);
        rx_ready[ch] = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rx0_drv = 1'b1; rx1_drv = 1'b1; loop_en = 1'b0;
        tx_data = '0; tx_valid = '0; rx_ready = '0; err_clear = 1'b0; rtk_status = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 2'b11);
        check("rst_tx_ready", tx_ready, 2'b00);
        check("rst_rx_valid", rx_valid, 2'b00);
        check("rst_overflow", rx_overflow, 2'b00);
        check("rst_frame_err", frame_err, 2'b00);
        check("rst_rtk_sync", rtk_status_sync, 1'b0);
        reset = 1'b0;
        #1;
        check("ready_before_edge", tx_ready, 2'b00);
        @(negedge clk);
        check("ready_after_edge", tx_ready, 2'b11);

        // Loopback ch0 TX -> ch1 RX
        loop_en = 1'b1;
        tx_send(8'hA5, "lb_a5");
        tx_send(8'h3C, "lb_3c");
        repeat (20) @(negedge clk);
        pop_check(1, 8'hA5, "lb_rx0");
        pop_check(1, 8'h3C, "lb_rx1");
        check("lb_empty", rx_valid[1], 1'b0);
        check("lb_frame_err", frame_err, 2'b00);
        check("lb_overflow", rx_overflow, 2'b00);
        loop_en = 1'b0;

        // Glitch
        rx0_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx0_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_push", rx_valid[0], 1'b0);
        check("glitch_no_ferr", frame_err[0], 1'b0);

        // Framing error followed by a long break
        rx_send(0, 8'h55, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_set", frame_err, 2'b01);
        check("ferr_fifo_empty", rx_valid[0], 1'b0);
        pulse_clear();
        check("ferr_cleared", frame_err[0], 1'b0);
        repeat (180) @(negedge clk);
        check("ferr_single_event", frame_err[0], 1'b0);
        rx0_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_after_break", frame_err[0], 1'b0);
        check("ferr_no_push", rx_valid[0], 1'b0);

        // Overflow: 5 bytes into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            rx_send(0, 8'(i), 1'b1, 1'b0);
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("ovf_set", rx_overflow, 2'b01);
        for (int i = 1; i <= 4; i++) pop_check(0, 8'(i), $sformatf("ovf_pop%0d", i));
        check("ovf_empty", rx_valid[0], 1'b0);
        pulse_clear();
        check("ovf_cleared", rx_overflow[0], 1'b0);

        // Overflow avoided: pop on the same edge as the 5th push
        for (int i = 1; i <= 4; i++) begin
            rx_send(0, 8'(i), 1'b1, 1'b0);
            repeat (2) @(negedge clk);
        end
        rx_send(0, 8'h05, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("ovf2_no_flag", rx_overflow[0], 1'b0);
        for (int i = 2; i <= 5; i++) pop_check(0, 8'(i), $sformatf("ovf2_pop%0d", i));
        check("ovf2_empty", rx_valid[0], 1'b0);

        // Reset during TX bit 3 and RX bit 5
        tx_data[7:0] = 8'h00;
        rx0_drv = 1'b0;
        repeat (16) @(negedge clk);
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (35) @(negedge clk);
        check("mid_tx_low", uart_tx[0], 1'b0);
        reset = 1'b1;
        #1;
        check("abort_uart_tx", uart_tx[0], 1'b1);
        check("abort_rx_valid", rx_valid[0], 1'b0);
        check("abort_tx_ready", tx_ready[0], 1'b0);
        rx0_drv = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_back", tx_ready, 2'b11);
        rx_send(0, 8'hFF, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        pop_check(0, 8'hFF, "abort_rx_ff");
        check("abort_flags", {rx_overflow, frame_err}, 4'b0000);

        // RTK status synchroniser
        rtk_status = 1'b1;
        @(negedge clk);
        check("rtk_rise_1cyc", rtk_status_sync, 1'b0);
        @(negedge clk);
        check("rtk_rise_2cyc", rtk_status_sync, 1'b1);
        rtk_status = 1'b0;
        @(negedge clk);
        check("rtk_fall_1cyc", rtk_status_sync, 1'b1);
        @(negedge clk);
        check("rtk_fall_2cyc", rtk_status_sync, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
